fm_demod: RTL and testbench

Parametrised FM discriminator stage for the radio datapath. It pops paired I/Q samples from two upstream FIFOs and forms the conjugate product with the previous sample. It then computes the quantised quadrature-arctan phase difference, using a sequential restoring divider, and pushes the gain-scaled result into a downstream FIFO. It replaces the fixed-width demodulator wrapper, adding configurable fixed-point scale, π/4 constant, output gain and full FIFO backpressure.

---
 rtl/fm_demod.sv | 234 +++++++++++++++++++++++
 tb/tb_fm_demod.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fm_demod.sv
// FM discriminator stage: pops paired I/Q samples, forms the conjugate
// product with the previous sample, derives the quadrature-arctan phase
// step through a sequential restoring divider and pushes the gain-scaled
// angle into the output FIFO.
module fm_demod #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int QUAD1      = 804,
  parameter int GAIN       = 758
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] I_dout,
  input  logic                  I_empty,
  output logic                  I_rd_en,
  input  logic [DATA_WIDTH-1:0] Q_dout,
  input  logic                  Q_empty,
  output logic                  Q_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int W     = DATA_WIDTH;
  localparam int W2    = 2 * DATA_WIDTH;
  localparam int QUAD3 = 3 * QUAD1;
  localparam int CW    = (W > 1) ? $clog2(W) : 1;

  localparam logic signed [W-1:0] QUAD1_C  = W'(QUAD1);
  localparam logic signed [W-1:0] QUAD3_C  = W'(QUAD3);
  localparam logic signed [W-1:0] GAIN_C   = W'(GAIN);
  localparam logic        [W-1:0] ONE_C    = W'(1);
  localparam logic       [CW-1:0] CNT_LOAD = CW'(W - 1);
  localparam logic       [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic       [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    ST_READ  = 3'd0,
    ST_MULT  = 3'd1,
    ST_PREP  = 3'd2,
    ST_DIV   = 3'd3,
    ST_SCALE = 3'd4,
    ST_WRITE = 3'd5
  } state_t;

  // Magnitude of a two's complement value (the most negative value wraps).
  function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] v);
    logic [W-1:0] r;
    if (v[W-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Sign-extend to double width so products are formed at full precision.
  function automatic logic signed [W2-1:0] sext2(input logic signed [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  // Architectural state
  state_t                 state_q;
  logic signed [W-1:0]    samp_i_q, samp_q_q;
  logic signed [W-1:0]    prev_i_q, prev_q_q;
  logic signed [W-1:0]    re_q, im_q;
  logic signed [W-1:0]    base_q;
  logic        [W-1:0]    quot_q;     // dividend shifts out, quotient shifts in
  logic        [W-1:0]    rem_q;
  logic        [W-1:0]    den_q;
  logic                   div_neg_q;
  logic        [CW-1:0]   cnt_q;
  logic        [W-1:0]    out_din_q;
  logic                   rd_en_q;
  logic                   wr_en_q;

  // Conjugate product terms
  logic signed [W2-1:0]   p_ii_s, p_qq_s, p_iq_s, p_qi_s;
  logic signed [W2:0]     re_sum_s, im_sum_s;
  logic signed [W-1:0]    re_d, im_d;

  // Divider set-up terms
  logic        [W-1:0]    abs_y_d, abs_r_d, den_d, dividend_d;
  logic signed [W-1:0]    num_d, num_quant_d, base_d;

  // Divider iteration terms
  logic        [W:0]      trial_d;
  logic        [W:0]      den_ext_d;
  logic        [W-1:0]    rem_next_d, quot_next_d;

  // Angle and gain terms
  logic signed [W-1:0]    q_d, angle_raw_d, angle_d, out_d;
  logic signed [W2-1:0]   ang_prod_s, gain_prod_s;

  // Conjugate product of the captured sample with the previous one
  always_comb begin
    p_ii_s   = sext2(prev_i_q) * sext2(samp_i_q);
    p_qq_s   = sext2(prev_q_q) * sext2(samp_q_q);
    p_iq_s   = sext2(prev_i_q) * sext2(samp_q_q);
    p_qi_s   = sext2(prev_q_q) * sext2(samp_i_q);
    re_sum_s = {p_ii_s[W2-1], p_ii_s} + {p_qq_s[W2-1], p_qq_s};
    im_sum_s = {p_iq_s[W2-1], p_iq_s} - {p_qi_s[W2-1], p_qi_s};
    re_d     = W'(re_sum_s >>> BITS);
    im_d     = W'(im_sum_s >>> BITS);
  end

  // Numerator, denominator and quadrant base for the arctan approximation
  always_comb begin
    abs_y_d = abs_val(im_q) + ONE_C;
    abs_r_d = abs_val(re_q);
    if (!re_q[W-1]) begin
      num_d  = re_q - abs_y_d;
      base_d = QUAD1_C;
    end else begin
      num_d  = re_q + abs_y_d;
      base_d = QUAD3_C;
    end
    den_d       = abs_r_d + abs_y_d;
    num_quant_d = num_d <<< BITS;
    dividend_d  = abs_val(num_quant_d);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial_d   = {rem_q, quot_q[W-1]};
    den_ext_d = {1'b0, den_q};
    if (trial_d >= den_ext_d) begin
      rem_next_d  = W'(trial_d - den_ext_d);
      quot_next_d = {quot_q[W-2:0], 1'b1};
    end else begin
      rem_next_d  = trial_d[W-1:0];
      quot_next_d = {quot_q[W-2:0], 1'b0};
    end
  end

  // Signed quotient to angle, mirrored for negative imaginary part, then gain
  always_comb begin
    if (div_neg_q) begin
      q_d = -quot_q;
    end else begin
      q_d = quot_q;
    end
    ang_prod_s  = sext2(QUAD1_C) * sext2(q_d);
    angle_raw_d = base_q - W'(ang_prod_s >>> BITS);
    if (im_q[W-1]) begin
      angle_d = -angle_raw_d;
    end else begin
      angle_d = angle_raw_d;
    end
    gain_prod_s = sext2(GAIN_C) * sext2(angle_d);
    out_d       = W'(gain_prod_s >>> BITS);
  end

  // Sequencer with datapath registers and registered FIFO handshakes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_READ;
      samp_i_q  <= '0;
      samp_q_q  <= '0;
      prev_i_q  <= '0;
      prev_q_q  <= '0;
      re_q      <= '0;
      im_q      <= '0;
      base_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      div_neg_q <= 1'b0;
      cnt_q     <= CNT_ZERO;
      out_din_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_READ: begin
          // Both FIFOs must have data so they are always popped together.
          if (!I_empty && !Q_empty) begin
            rd_en_q  <= 1'b1;
            samp_i_q <= I_dout;
            samp_q_q <= Q_dout;
            state_q  <= ST_MULT;
          end
        end
        ST_MULT: begin
          re_q     <= re_d;
          im_q     <= im_d;
          prev_i_q <= samp_i_q;
          prev_q_q <= samp_q_q;
          state_q  <= ST_PREP;
        end
        ST_PREP: begin
          quot_q    <= dividend_d;
          rem_q     <= '0;
          den_q     <= den_d;
          div_neg_q <= num_d[W-1];
          base_q    <= base_d;
          cnt_q     <= CNT_LOAD;
          state_q   <= ST_DIV;
        end
        ST_DIV: begin
          quot_q <= quot_next_d;
          rem_q  <= rem_next_d;
          if (cnt_q == CNT_ZERO) begin
            state_q <= ST_SCALE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SCALE: begin
          out_din_q <= out_d;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          // out_din stays put while the downstream FIFO is full.
          if (!out_full) begin
            wr_en_q <= 1'b1;
            state_q <= ST_READ;
          end
        end
        default: begin
          state_q <= ST_READ;
        end
      endcase
    end
  end

  assign I_rd_en   = rd_en_q;
  assign Q_rd_en   = rd_en_q;
  assign out_din   = out_din_q;
  assign out_wr_en = wr_en_q;

endmodule

// File: tb/tb_fm_demod.sv
// Directed bench for fm_demod: FIFO models around the DUT, a posedge
// recorder of pops and pushes, and hand-computed expected outputs.
module tb_fm_demod;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] I_dout, Q_dout, out_din;
  logic        I_empty, Q_empty, I_rd_en, Q_rd_en, out_wr_en;
  logic        out_full = 1'b0;

  logic [31:0] i_mem [0:63];
  logic [31:0] q_mem [0:63];
  int          i_wp, i_rp, q_wp, q_rp;

  int          cyc, rd_n, wr_n, lock_err;
  int          rd_at [0:63];
  int          wr_at [0:63];
  logic [31:0] wr_v  [0:63];

  int          checks, failures;
  int          rb, wb;
  logic [31:0] hold_val;

  fm_demod dut (
    .clock    (clock),
    .reset    (reset),
    .I_dout   (I_dout),
    .I_empty  (I_empty),
    .I_rd_en  (I_rd_en),
    .Q_dout   (Q_dout),
    .Q_empty  (Q_empty),
    .Q_rd_en  (Q_rd_en),
    .out_din  (out_din),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  always #5 clock = ~clock;

  assign I_empty = (i_rp == i_wp);
  assign Q_empty = (q_rp == q_wp);
  assign I_dout  = i_mem[i_rp[5:0]];
  assign Q_dout  = q_mem[q_rp[5:0]];

  // FIFO pops and output pushes, stamped with the cycle they occupied
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (I_rd_en) i_rp <= i_rp + 1;
    if (Q_rd_en) q_rp <= q_rp + 1;
    if (I_rd_en != Q_rd_en) lock_err <= lock_err + 1;
    if (I_rd_en || Q_rd_en) begin
      rd_at[rd_n[5:0]] <= cyc;
      rd_n <= rd_n + 1;
    end
    if (out_wr_en) begin
      wr_at[wr_n[5:0]] <= cyc;
      wr_v[wr_n[5:0]]  <= out_din;
      wr_n <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] wv(input int k);
    return wr_v[k[5:0]];
  endfunction

  function automatic int wa(input int k);
    return wr_at[k[5:0]];
  endfunction

  function automatic int ra(input int k);
    return rd_at[k[5:0]];
  endfunction

  task automatic push(input logic [31:0] iv, input logic [31:0] qv);
    i_mem[i_wp[5:0]] = iv;
    q_mem[q_wp[5:0]] = qv;
    i_wp = i_wp + 1;
    q_wp = q_wp + 1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // First sample is against (0,0) and gives 1190; the second is checked
  task automatic pair_test(input string tag, input logic [31:0] i1, input logic [31:0] q1,
                           input logic [31:0] i2, input logic [31:0] q2,
                           input logic [31:0] exp2);
    do_reset();
    wb = wr_n;
    push(i1, q1);
    push(i2, q2);
    run(85);
    check({tag, "_count"},  wr_n - wb, 32'd2);
    check({tag, "_first"},  wv(wb), 32'd1190);
    check({tag, "_second"}, wv(wb + 1), exp2);
    check({tag, "_period"}, wa(wb + 1) - wa(wb), 32'd37);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset state
    @(negedge clock);
    check("rst_i_rd_en",   {31'd0, I_rd_en},   32'd0);
    check("rst_q_rd_en",   {31'd0, Q_rd_en},   32'd0);
    check("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    check("rst_out_din",   out_din,            32'd0);
    reset = 1'b0;

    // (0,0) against reset history: q=-1024, angle=1608, out 1190 at cycle 36
    rb = rd_n;
    wb = wr_n;
    push(32'd0, 32'd0);
    run(45);
    check("zero_count",   wr_n - wb, 32'd1);
    check("zero_value",   wv(wb), 32'd1190);
    check("zero_latency", wa(wb) - ra(rb), 32'd36);

    // Quadrature steps, same-phase and opposite-phase samples
    pair_test("pos90",  32'd1024, 32'd0, 32'd0,      32'd1024, 32'd1190);
    pair_test("neg90",  32'd1024, 32'd0, 32'd0,      -32'sd1024, -32'sd1191);
    pair_test("same",   32'd1024, 32'd0, 32'd1024,   32'd0,    32'd1);
    pair_test("oppose", 32'd1024, 32'd0, -32'sd1024, 32'd0,    32'd2379);

    // I holds three entries while Q is empty: nothing may be popped
    do_reset();
    rb = rd_n;
    wb = wr_n;
    i_mem[i_wp[5:0]] = 32'd0; i_wp = i_wp + 1;
    i_mem[i_wp[5:0]] = 32'd0; i_wp = i_wp + 1;
    i_mem[i_wp[5:0]] = 32'd0; i_wp = i_wp + 1;
    run(50);
    check("qempty_no_pop",   rd_n - rb, 32'd0);
    check("qempty_no_write", wr_n - wb, 32'd0);
    q_mem[q_wp[5:0]] = 32'd0; q_wp = q_wp + 1;
    q_mem[q_wp[5:0]] = 32'd0; q_wp = q_wp + 1;
    q_mem[q_wp[5:0]] = 32'd0; q_wp = q_wp + 1;
    run(121);
    check("burst_pops",    rd_n - rb, 32'd3);
    check("burst_writes",  wr_n - wb, 32'd3);
    check("burst_val0",    wv(wb),     32'd1190);
    check("burst_val2",    wv(wb + 2), 32'd1190);
    check("burst_gap01",   wa(wb + 1) - wa(wb),     32'd37);
    check("burst_gap12",   wa(wb + 2) - wa(wb + 1), 32'd37);
    check("burst_drained", i_wp - i_rp, 32'd0);

    // Backpressure: out_full held across the WRITE state
    do_reset();
    rb = rd_n;
    wb = wr_n;
    out_full = 1'b1;
    push(32'd0, 32'd0);
    push(32'd0, 32'd0);
    run(60);
    hold_val = out_din;
    check("full_value_mid", hold_val, 32'd1190);
    run(80);
    check("full_value_end", out_din, hold_val);
    check("full_wr_low",    {31'd0, out_wr_en}, 32'd0);
    check("full_no_write",  wr_n - wb, 32'd0);
    check("full_one_pop",   rd_n - rb, 32'd1);
    out_full = 1'b0;
    run(3);
    check("release_write",  wr_n - wb, 32'd1);
    check("release_pop",    rd_n - rb, 32'd2);
    check("release_rd_gap", ra(rb + 1) - wa(wb), 32'd1);
    run(40);
    check("release_second", wv(wb + 1), 32'd1190);

    // Reset in the middle of the divide discards the in-flight sample
    rb = rd_n;
    wb = wr_n;
    push(32'd1024, 32'd0);
    run(13);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_din", out_din, 32'd0);
    check("midrst_wr_en",   {31'd0, out_wr_en}, 32'd0);
    check("midrst_rd_en",   {30'd0, I_rd_en, Q_rd_en}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    run(50);
    check("midrst_no_write", wr_n - wb, 32'd0);
    check("midrst_one_pop",  rd_n - rb, 32'd1);
    push(32'd1024, 32'd0);
    run(45);
    check("midrst_next_cnt", wr_n - wb, 32'd1);
    check("midrst_next_val", wv(wb), 32'd1190);

    check("lockstep", lock_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
